// File: rtl/frog_controller.sv
// Frogger game-logic stage: debounced button moves, frog grid position, lives and the PLAY/HIT/OVER flow.
// The outputs feed the VGA renderer directly.
module frog_controller #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int HIT_FRAMES   = 30,
    parameter int START_COL    = 10,
    parameter int START_ROW    = 14,
    parameter int MAX_COL      = 19,
    parameter int MAX_ROW      = 14,
    parameter int START_LIVES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    output logic [4:0] frog_col,
    output logic [3:0] frog_row,
    output logic [1:0] lives,
    output logic       hit,
    output logic       score_tick,
    output logic       game_over
);
    localparam logic [1:0] PLAY = 2'd0;
    localparam logic [1:0] HIT  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
    localparam int FW = $clog2(HIT_FRAMES + 1) + 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [FW-1:0] FRM_MAX  = FW'(HIT_FRAMES - 1);
    localparam logic [4:0]    S_COL    = 5'(START_COL);
    localparam logic [3:0]    S_ROW    = 4'(START_ROW);
    localparam logic [4:0]    M_COL    = 5'(MAX_COL);
    localparam logic [3:0]    M_ROW    = 4'(MAX_ROW);
    localparam logic [1:0]    S_LIVES  = 2'(START_LIVES);

    logic [3:0]    raw;
    logic [3:0]    sync1, sync2, deb, deb_q, req;
    logic [DW-1:0] cnt [4];
    logic [1:0]    state;
    logic [FW-1:0] frame_cnt;

    // bit order: 0=up 1=down 2=left 3=right
    assign raw = {btn_right, btn_left, btn_down, btn_up};
    assign req = deb & ~deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                // counter only runs while the synced level disagrees with the accepted one
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign hit       = (state == HIT);
    assign game_over = (state == OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLAY;
            frog_col   <= S_COL;
            frog_row   <= S_ROW;
            lives      <= S_LIVES;
            score_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            score_tick <= 1'b0;
            case (state)
                PLAY: begin
                    if (frame_tick && collision) begin
                        state     <= HIT;
                        frame_cnt <= '0;
                        if (lives != 2'd0) lives <= lives - 1'b1;
                    end else if (req[0]) begin
                        // reaching row 0 scores and respawns in one step
                        if (frog_row == 4'd1) begin
                            score_tick <= 1'b1;
                            frog_col   <= S_COL;
                            frog_row   <= S_ROW;
                        end else if (frog_row != 4'd0) begin
                            frog_row <= frog_row - 1'b1;
                        end
                    end else if (req[1]) begin
                        if (frog_row != M_ROW) frog_row <= frog_row + 1'b1;
                    end else if (req[2]) begin
                        if (frog_col != 5'd0) frog_col <= frog_col - 1'b1;
                    end else if (req[3]) begin
                        if (frog_col != M_COL) frog_col <= frog_col + 1'b1;
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        if (frame_cnt == FRM_MAX) begin
                            frame_cnt <= '0;
                            if (lives == 2'd0) begin
                                state <= OVER;
                            end else begin
                                state    <= PLAY;
                                frog_col <= S_COL;
                                frog_row <= S_ROW;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (|req) begin
                        state    <= PLAY;
                        lives    <= S_LIVES;
                        frog_col <= S_COL;
                        frog_row <= S_ROW;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end
endmodule
